// File: rtl/booth_mac_pkg.sv
// booth_mac_pkg: widths, opcodes, saturation limits and FSM states shared by the MAC stage
package booth_mac_pkg;
  localparam int ACC_W = 64;
  localparam int OPND_W = 32;
  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_MAC = 2'b01;
  localparam logic [1:0] OP_MSUB = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/booth_mul.sv
// booth_mul: combinational 32x32 signed radix-4 Booth multiplier
// Ports: a (signed multiplicand), b (signed multiplier), product (signed 64-bit a*b)
module booth_mul
  import booth_mac_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [ACC_W-1:0]  product
);
  logic [ACC_W-1:0] ax;
  logic [OPND_W:0] bx;
  function automatic logic [ACC_W-1:0] booth_pp(input logic [2:0] g, input logic [ACC_W-1:0] x);
    return (g == 3'b001 || g == 3'b010) ? x :
           (g == 3'b011) ? x << 1 :
           (g == 3'b100) ? -(x << 1) :
           (g == 3'b101 || g == 3'b110) ? -x : '0;
  endfunction
  assign ax = {{(ACC_W-OPND_W){a[OPND_W-1]}}, a};
  // Implicit zero below the LSB forms the first Booth triplet.
  assign bx = {b, 1'b0};
  always_comb begin
    product = '0;
    for (int i = 0; i < OPND_W/2; i++)
      product = product + (booth_pp(bx[2*i +: 3], ax) << (2*i));
  end
endmodule

// File: rtl/booth_mac_acc.sv
// booth_mac_acc: handshaked multiply-accumulate stage around booth_mul with optional saturation
// Ports: clk, rst_n (async active-low); in_valid/in_ready with in_a, in_b, in_op (MUL/MAC/MSUB/CLR);
//        out_valid/out_ready with out_result (accumulator), out_ovf (this op), out_sticky_ovf (since CLR/reset)
module booth_mac_acc
  import booth_mac_pkg::*;
#(
  parameter bit SAT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] in_a,
  input  logic [OPND_W-1:0] in_b,
  input  logic [1:0]        in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_result,
  output logic              out_ovf,
  output logic              out_sticky_ovf
);
  state_t state, state_nx;
  logic [OPND_W-1:0] op_a, op_b;
  logic [1:0] op_code;
  logic [ACC_W-1:0] acc, acc_nx, product;
  logic [ACC_W:0] sum;
  logic ovf_nx, sticky;
  booth_mul u_mul (
    .a(op_a),
    .b(op_b),
    .product(product)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Handshake outputs depend only on state, so no input-to-output combinational path exists.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = EXEC;
      end
      EXEC: state_nx = RESP;
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  // One guard bit: the 65-bit sum cannot wrap, and disagreement of its top two bits flags overflow.
  assign sum = (op_code == OP_MSUB) ? {acc[ACC_W-1], acc} - {product[ACC_W-1], product}
                                    : {acc[ACC_W-1], acc} + {product[ACC_W-1], product};
  assign ovf_nx = (op_code == OP_MAC || op_code == OP_MSUB) && (sum[ACC_W] ^ sum[ACC_W-1]);
  assign acc_nx = (op_code == OP_CLR) ? '0 :
                  (op_code == OP_MUL) ? product :
                  (ovf_nx && SAT_EN) ? (sum[ACC_W] ? SAT_MIN : SAT_MAX) : sum[ACC_W-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
      op_code <= OP_MUL;
      acc <= '0;
      out_ovf <= 1'b0;
      sticky <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        op_a <= in_a;
        op_b <= in_b;
        op_code <= in_op;
      end
      if (state == EXEC) begin
        acc <= acc_nx;
        out_ovf <= ovf_nx;
        sticky <= (op_code == OP_CLR) ? 1'b0 : sticky | ovf_nx;
      end
    end
  // The accumulator is only written in EXEC, so it doubles as the held response value.
  assign out_result = acc;
  assign out_sticky_ovf = sticky;
endmodule

// File: tb/tb_booth_mac_acc.sv
// tb_booth_mac_acc: randomized and directed bench for saturating and wrapping booth_mac_acc instances
module tb_booth_mac_acc;
  localparam logic signed [65:0] MAXV = 66'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] MINV = -66'sh8000_0000_0000_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [1:0] in_op = '0;
  logic [1:0] rdy, vld, ovf, stk;
  logic [63:0] res [2];
  logic signed [63:0] m_acc [2];
  logic m_stk [2];
  int nvec = 0;
  int nmis = 0;
  always #5 clk = ~clk;
  booth_mac_acc #(.SAT_EN(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(vld[0]), .out_ready(out_ready),
    .out_result(res[0]), .out_ovf(ovf[0]), .out_sticky_ovf(stk[0])
  );
  booth_mac_acc #(.SAT_EN(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(vld[1]), .out_ready(out_ready),
    .out_result(res[1]), .out_ovf(ovf[1]), .out_sticky_ovf(stk[1])
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  // Reference: exact integer arithmetic, then clamp or wrap; instance 0 saturates, instance 1 wraps.
  function automatic void model_step(input int m, input logic [31:0] a, input logic [31:0] b,
                                     input logic [1:0] op, output logic [63:0] r, output logic o);
    longint p;
    logic signed [65:0] s;
    p = longint'($signed(a)) * longint'($signed(b));
    o = 1'b0;
    if (op == 2'b11) begin
      m_acc[m] = '0;
      m_stk[m] = 1'b0;
      r = '0;
      return;
    end
    if (op == 2'b00) s = p;
    else if (op == 2'b01) s = m_acc[m] + p;
    else s = m_acc[m] - p;
    o = (s > MAXV) || (s < MINV);
    r = (o && m == 0) ? ((s > 0) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000) : s[63:0];
    m_acc[m] = r;
    m_stk[m] = m_stk[m] | o;
  endfunction
  function automatic logic [31:0] pick();
    int k;
    k = $urandom_range(0, 3);
    return (k == 0) ? 32'h8000_0000 : (k == 1) ? 32'h7FFF_FFFF :
           (k == 2) ? 32'($urandom_range(0, 255)) - 32'd128 : 32'($urandom);
  endfunction
  // Called at a negedge with the DUTs idle; returns at the negedge after the output handshake.
  task automatic xact(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input int hold, input logic ro, input logic nv,
                      input logic [31:0] na, input logic [31:0] nb, input logic [1:0] nop);
    logic [63:0] er [2];
    logic eo [2];
    logic [63:0] held;
    int cnt;
    in_a = a;
    in_b = b;
    in_op = op;
    in_valid = 1'b1;
    out_ready = ro;
    check("in_ready", 64'(rdy), 64'h3);
    @(negedge clk);
    in_valid = nv;
    in_a = na;
    in_b = nb;
    in_op = nop;
    cnt = 1;
    while (vld != 2'b11 && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    check("latency", 64'(cnt), 64'd2);
    if (vld != 2'b11) return;
    for (int m = 0; m < 2; m++) begin
      model_step(m, a, b, op, er[m], eo[m]);
      check($sformatf("result%0d", m), res[m], er[m]);
      check($sformatf("ovf%0d", m), 64'(ovf[m]), 64'(eo[m]));
      check($sformatf("sticky%0d", m), 64'(stk[m]), 64'(m_stk[m]));
    end
    held = res[0];
    repeat (hold) begin
      @(negedge clk);
      check("hold_result", res[0], held);
      check("hold_rdy_vld", 64'({rdy, vld}), 64'b0011);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("back_idle", 64'({rdy, vld}), 64'b1100);
  endtask
  task automatic op1(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    xact(a, b, op, 0, 1'b0, 1'b0, '0, '0, 2'b00);
  endtask
  initial begin
    for (int m = 0; m < 2; m++) begin
      m_acc[m] = '0;
      m_stk[m] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("rst_result0", res[0], 64'd0);
    check("rst_result1", res[1], 64'd0);
    check("rst_flags", 64'({rdy, vld, ovf, stk}), 64'hC0);
    rst_n = 1'b1;
    @(negedge clk);
    op1(32'd20, -32'sd3, 2'b00);
    check("mul_const", res[0], 64'hFFFF_FFFF_FFFF_FFC4);
    op1(32'd77, 32'd88, 2'b01);
    check("mac_const", res[0], 64'd6716);
    op1(-32'sd90, -32'sd90, 2'b10);
    check("msub_const", res[0], 64'hFFFF_FFFF_FFFF_FA98);
    op1(32'h8000_0000, 32'h8000_0000, 2'b00);
    check("mul_big", res[1], 64'h4000_0000_0000_0000);
    op1(32'h8000_0000, 32'h8000_0000, 2'b01);
    check("sat_const", res[0], 64'h7FFF_FFFF_FFFF_FFFF);
    check("wrap_const", res[1], 64'h8000_0000_0000_0000);
    op1(32'd1, 32'd1, 2'b01);
    check("sat_hold_const", res[0], 64'h7FFF_FFFF_FFFF_FFFF);
    check("sat_sticky", 64'(stk), 64'h3);
    op1(32'd5, 32'd6, 2'b11);
    check("clr_const", res[0], 64'd0);
    check("clr_sticky", 64'(stk), 64'h0);
    xact(32'd5, 32'd7, 2'b01, 5, 1'b0, 1'b1, 32'd11, 32'd13, 2'b01);
    op1(32'd11, 32'd13, 2'b01);
    check("held_ops_const", res[0], 64'd178);
    in_a = 32'd100;
    in_b = 32'd100;
    in_op = 2'b01;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_vld", 64'(vld), 64'h0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_res0", res[0], 64'd0);
    check("async_rst_res1", res[1], 64'd0);
    check("async_rst_flags", 64'({rdy, vld, ovf, stk}), 64'hC0);
    for (int m = 0; m < 2; m++) begin
      m_acc[m] = '0;
      m_stk[m] = 1'b0;
    end
    @(negedge clk);
    check("rst_held_flags", 64'({rdy, vld, ovf, stk}), 64'hC0);
    rst_n = 1'b1;
    @(negedge clk);
    op1(32'd1, 32'd98765, 2'b01);
    check("post_rst_const", res[0], 64'd98765);
    for (int n = 0; n < 60; n++) begin
      int r;
      logic [1:0] op;
      logic ro;
      r = $urandom_range(0, 9);
      op = (r == 0) ? 2'b11 : (r < 3) ? 2'b00 : (r < 7) ? 2'b01 : 2'b10;
      ro = 1'($urandom_range(0, 1));
      xact(pick(), pick(), op, ro ? 0 : $urandom_range(0, 2), ro, 1'b0, '0, '0, 2'b00);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
